// File: rtl/jtag_tap_monitor.sv
// Passive JTAG TAP observer: synchronises and deglitches TCK/TMS/TDI, tracks the
// 16-state TAP controller, captures IR/DR scan data and queues every state change
// into a small first-word-fall-through event FIFO.
module jtag_tap_monitor #(
  parameter int FILT_LEN = 4,
  parameter int IR_LEN   = 8,
  parameter int DR_LEN   = 32,
  parameter int FIFO_AW  = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              jtag_tck,
  input  logic              jtag_tms,
  input  logic              jtag_tdi,
  output logic [3:0]        tap_state,
  output logic [IR_LEN-1:0] ir_value,
  output logic [DR_LEN-1:0] dr_value,
  output logic [6:0]        dr_bits,
  output logic              ir_update,
  output logic              dr_update,
  output logic              evt_valid,
  output logic [7:0]        evt_data,
  input  logic              evt_ready,
  output logic              evt_overflow,
  input  logic              ovf_clr
);

  localparam int CW    = (FILT_LEN < 1) ? 1 : $clog2(FILT_LEN + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] FILT_TOP = (FILT_LEN > 0) ? CW'(FILT_LEN - 1) : '0;

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
    UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
  } tap_e;

  // ---------------- input path: bit 0 = TCK, 1 = TMS, 2 = TDI
  logic [2:0]         pin_raw;
  logic [2:0]         s1_q, s2_q;
  logic [2:0]         filt_q, filt_d, filt;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic               tck_prev_q;
  logic               tck_rise, tms, tdi;

  assign pin_raw = {jtag_tdi, jtag_tms, jtag_tck};

  // Filter: the output follows the synced pin only after it has differed for FILT_LEN cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (FILT_LEN == 0) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FILT_TOP) filt_d[i] = s2_q[i];
        else                      cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
  end

  assign filt     = (FILT_LEN == 0) ? s2_q : filt_q;
  assign tck_rise = filt[0] & ~tck_prev_q;
  assign tms      = filt[1];
  assign tdi      = filt[2];

  // Synchroniser, filter state and TCK edge history
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      cnt_q      <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      s1_q       <= pin_raw;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      tck_prev_q <= filt[0];
    end
  end

  // ---------------- TAP controller and scan capture
  tap_e              state_q, state_d, nxt;
  logic [DR_LEN-1:0] sr_dr_q, sr_dr_d, dr_value_q, dr_value_d;
  logic [IR_LEN-1:0] sr_ir_q, sr_ir_d, ir_value_q, ir_value_d;
  logic [DR_LEN:0]   dr_cat;
  logic [IR_LEN:0]   ir_cat;
  logic [6:0]        dr_bits_q, dr_bits_d;
  logic              dr_update_q, dr_update_d, ir_update_q, ir_update_d;

  assign dr_cat = {tdi, sr_dr_q};
  assign ir_cat = {tdi, sr_ir_q};

  // IEEE 1149.1 next-state function from the current state and filtered TMS
  always_comb begin
    nxt = state_q;
    case (state_q)
      TLR:     nxt = tms ? TLR    : RTI;
      RTI:     nxt = tms ? SEL_DR : RTI;
      SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR:  nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  nxt = tms ? SEL_DR : RTI;
      SEL_IR:  nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR:  nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  // Scan data path: clear when leaving capture, LSB-first shift, latch on entry to update
  always_comb begin
    state_d     = state_q;
    sr_dr_d     = sr_dr_q;
    sr_ir_d     = sr_ir_q;
    dr_bits_d   = dr_bits_q;
    dr_value_d  = dr_value_q;
    ir_value_d  = ir_value_q;
    dr_update_d = 1'b0;
    ir_update_d = 1'b0;
    if (tck_rise) begin
      state_d = nxt;
      case (state_q)
        CAP_DR: begin
          sr_dr_d   = '0;
          dr_bits_d = '0;
        end
        SH_DR: begin
          sr_dr_d = dr_cat[DR_LEN:1];
          if (dr_bits_q < 7'(DR_LEN)) dr_bits_d = dr_bits_q + 7'd1;
        end
        CAP_IR:  sr_ir_d = '0;
        SH_IR:   sr_ir_d = ir_cat[IR_LEN:1];
        default: ;
      endcase
      if (nxt == UPD_DR) begin
        dr_value_d  = sr_dr_q;
        dr_update_d = 1'b1;
      end
      if (nxt == UPD_IR) begin
        ir_value_d  = sr_ir_q;
        ir_update_d = 1'b1;
      end
    end
  end

  // TAP state and scan registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= TLR;
      sr_dr_q     <= '0;
      sr_ir_q     <= '0;
      dr_bits_q   <= '0;
      dr_value_q  <= '0;
      ir_value_q  <= '0;
      dr_update_q <= 1'b0;
      ir_update_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_dr_q     <= sr_dr_d;
      sr_ir_q     <= sr_ir_d;
      dr_bits_q   <= dr_bits_d;
      dr_value_q  <= dr_value_d;
      ir_value_q  <= ir_value_d;
      dr_update_q <= dr_update_d;
      ir_update_q <= ir_update_d;
    end
  end

  // ---------------- event FIFO (extra pointer MSB separates full from empty)
  logic [3:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, push, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push  = tck_rise && (nxt != state_q);
  assign pop   = !empty && evt_ready;
  assign wr_en = push && (!full || pop);

  // Pointer update; a drop beats a same-cycle overflow clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  // FIFO storage and pointers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= nxt;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tap_state    = state_q;
  assign ir_value     = ir_value_q;
  assign dr_value     = dr_value_q;
  assign dr_bits      = dr_bits_q;
  assign ir_update    = ir_update_q;
  assign dr_update    = dr_update_q;
  assign evt_valid    = !empty;
  assign evt_data     = {4'h0, mem_q[rd_ptr_q[FIFO_AW-1:0]]};
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_jtag_tap_monitor.sv
// Bench for jtag_tap_monitor: directed TAP walks plus random TMS/TDI/pop traffic,
// all checked against a table-driven TAP and queue model.
module tb_jtag_tap_monitor;

  localparam int FL = 4, IRL = 8, DRL = 4, AW = 3;

  logic           sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic           jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0;
  logic [3:0]     tap_state;
  logic [IRL-1:0] ir_value;
  logic [DRL-1:0] dr_value;
  logic [6:0]     dr_bits;
  logic           ir_update, dr_update, evt_valid, evt_overflow;
  logic [7:0]     evt_data;
  logic           evt_ready = 1'b0, ovf_clr = 1'b0;

  jtag_tap_monitor #(.FILT_LEN(FL), .IR_LEN(IRL), .DR_LEN(DRL), .FIFO_AW(AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .tap_state(tap_state), .ir_value(ir_value), .dr_value(dr_value), .dr_bits(dr_bits),
    .ir_update(ir_update), .dr_update(dr_update),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0, bad = 0;
  int dru_cnt = 0, iru_cnt = 0;

  // Cycles the update pulses are high
  always @(posedge sys_clk) begin
    if (dr_update) dru_cnt++;
    if (ir_update) iru_cnt++;
  end

  // Reference model
  int             nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int             nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int             m_st, m_bits, m_dru, m_iru;
  logic [DRL-1:0] m_sr_dr, m_dr;
  logic [IRL-1:0] m_sr_ir, m_ir;
  bit             m_ovf;
  int             q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bits = 0; m_sr_dr = '0; m_dr = '0; m_sr_ir = '0; m_ir = '0;
    m_ovf = 0; q.delete(); m_dru = dru_cnt; m_iru = iru_cnt;
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    int ns;
    ns = tms ? nx1[m_st] : nx0[m_st];
    if (m_st == 3)  begin m_sr_dr = '0; m_bits = 0; end
    if (m_st == 10) m_sr_ir = '0;
    if (m_st == 4) begin
      m_sr_dr = (m_sr_dr >> 1) | (DRL'(tdi) << (DRL - 1));
      if (m_bits < DRL) m_bits++;
    end
    if (m_st == 11) m_sr_ir = (m_sr_ir >> 1) | (IRL'(tdi) << (IRL - 1));
    if (ns == 8)  begin m_dr = m_sr_dr; m_dru++; end
    if (ns == 15) begin m_ir = m_sr_ir; m_iru++; end
    if (ns != m_st) begin
      if (q.size() < (1 << AW)) q.push_back(ns);
      else m_ovf = 1;
    end
    m_st = ns;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 64'(tap_state), 64'(m_st));
    chk({tag, ".dr_value"}, 64'(dr_value), 64'(m_dr));
    chk({tag, ".ir_value"}, 64'(ir_value), 64'(m_ir));
    chk({tag, ".dr_bits"}, 64'(dr_bits), 64'(m_bits));
    chk({tag, ".evt_valid"}, 64'(evt_valid), 64'(q.size() != 0));
    chk({tag, ".ovf"}, 64'(evt_overflow), 64'(m_ovf));
    chk({tag, ".dr_upd_cycles"}, 64'(dru_cnt), 64'(m_dru));
    chk({tag, ".ir_upd_cycles"}, 64'(iru_cnt), 64'(m_iru));
    if (q.size() != 0) chk({tag, ".evt_head"}, 64'(evt_data), 64'(q[0]));
  endtask

  // One full TCK period, slow enough for the synchroniser and filter
  task automatic pulse(input bit tms, input bit tdi);
    @(negedge sys_clk);
    jtag_tms = tms; jtag_tdi = tdi;
    repeat (2) @(negedge sys_clk);
    jtag_tck = 1'b1;
    repeat (8) @(negedge sys_clk);
    jtag_tck = 1'b0;
    repeat (8) @(negedge sys_clk);
    model_step(tms, tdi);
    check_all("pulse");
  endtask

  task automatic pop_one();
    int tmp;
    @(negedge sys_clk);
    chk("pop.valid", 64'(evt_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("pop.data", 64'(evt_data), 64'(q[0]));
      tmp = q.pop_front();
    end
    evt_ready = 1'b1;
    @(negedge sys_clk);
    evt_ready = 1'b0;
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
    @(negedge sys_clk);
    chk("drain.empty", 64'(evt_valid), 64'd0);
  endtask

  task automatic clear_ovf();
    @(negedge sys_clk);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    m_ovf = 0;
    chk("ovf_clr", 64'(evt_overflow), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ir_pat;
    int r;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_all("reset");
    chk("reset.dr_update", 64'(dr_update), 64'd0);
    chk("reset.ir_update", 64'(ir_update), 64'd0);

    // TLR holds under TMS=1, no events
    repeat (5) pulse(1'b1, 1'b0);
    chk("tlr_hold.state", 64'(tap_state), 64'd0);
    chk("tlr_hold.valid", 64'(evt_valid), 64'd0);

    // Latency: rise at the pin, state changes on the 7th edge with FILT_LEN=4
    @(negedge sys_clk);
    jtag_tms = 1'b0;
    repeat (2) @(negedge sys_clk);
    jtag_tck = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1 chk("latency.before", 64'(tap_state), 64'd0);
    @(posedge sys_clk);
    #1 chk("latency.at7", 64'(tap_state), 64'd1);
    @(negedge sys_clk);
    jtag_tck = 1'b0;
    repeat (8) @(negedge sys_clk);
    model_step(1'b0, 1'b0);
    check_all("latency");

    pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
    chk("walk.state", 64'(tap_state), 64'd4);
    chk("walk.qlen", 64'(q.size()), 64'd4);
    drain();

    // DR scan of 1,0,1,1
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    chk("dr.value", 64'(dr_value), 64'hD);
    chk("dr.bits", 64'(dr_bits), 64'd4);
    chk("dr.upd_cycles", 64'(dru_cnt), 64'd1);
    drain();

    // IR scan of 8'hA5
    ir_pat = 8'hA5;
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pulse(i == 7, ir_pat[i]);
    pulse(1'b1, 1'b0);
    chk("ir.value", 64'(ir_value), 64'hA5);
    chk("ir.dr_kept", 64'(dr_value), 64'hD);
    chk("ir.upd_cycles", 64'(iru_cnt), 64'd1);
    pulse(1'b0, 1'b0);
    drain();

    // Overflow: nine changes into an eight-deep FIFO
    begin
      bit seq [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
      for (int i = 0; i < 9; i++) pulse(seq[i], 1'b0);
    end
    chk("ovf.set", 64'(evt_overflow), 64'd1);
    chk("ovf.kept", 64'(q.size()), 64'd8);
    clear_ovf();
    chk("ovf.oldest", 64'(evt_data), 64'd2);
    drain();
    pop_one();

    // Glitch rejection, then a clean 6-cycle high
    @(negedge sys_clk);
    jtag_tms = 1'b0;
    repeat (2) @(negedge sys_clk);
    jtag_tck = 1'b1;
    repeat (2) @(negedge sys_clk);
    jtag_tck = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_all("glitch");
    jtag_tck = 1'b1;
    repeat (6) @(negedge sys_clk);
    jtag_tck = 1'b0;
    repeat (10) @(negedge sys_clk);
    model_step(1'b0, 1'b0);
    check_all("six_high");
    chk("six_high.state", 64'(tap_state), 64'd3);
    drain();

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      pulse($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      else if (r < 9) pop_one();
      else            clear_ovf();
    end
    drain();
    if (m_ovf) clear_ovf();

    // Reset in the middle of a DR shift
    while (m_st != 4) pulse(m_st == 1 ? 1'b1 : 1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1 chk("midrst.state", 64'(tap_state), 64'd0);
    chk("midrst.valid", 64'(evt_valid), 64'd0);
    chk("midrst.bits", 64'(dr_bits), 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    @(negedge sys_clk);
    check_all("midrst");
    pulse(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
